shift_reg_sequencer: RTL and testbench

//  Command-driven controller for the 8-bit multi-mode shift register (ctr/load_val/in_data/out_Q).

---
 rtl/shift_reg_sequencer.sv | 118 +++++++++++
 tb/tb_shift_reg_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_sequencer.sv
// Command-driven controller for the 8-bit multi-mode shift register: applies one
// register op for a commanded number of cycles and holds the register otherwise.
module shift_reg_sequencer #(
    parameter logic [7:0] TAPS = 8'h1D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_len,
    input  logic [7:0] cmd_data,
    input  logic       cmd_fb,
    input  logic       abort,
    input  logic [7:0] reg_q,
    output logic [2:0] ctr,
    output logic [7:0] load_val,
    output logic       in_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_SHIFT = 3'd5;

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic [2:0] idx;
    logic [2:0] op_q;
    logic [7:0] data_q;
    logic       fb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A zero-length command still passes through DONE so the requester sees a pulse.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    next_state = (cmd_len != 8'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (cnt == 8'd1) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 8'd0;
            idx    <= 3'd0;
            op_q   <= 3'd0;
            data_q <= 8'd0;
            fb_q   <= 1'b0;
        end else if (state == IDLE) begin
            if (cmd_valid) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                fb_q   <= cmd_fb;
                cnt    <= cmd_len;
                idx    <= 3'd0;
            end
        end else if (state == RUN) begin
            cnt <= cnt - 8'd1;
            idx <= idx + 3'd1;
        end
    end

    // The register has no hold code, so idle cycles reload it with its own value.
    always_comb begin
        ctr       = OP_LOAD;
        load_val  = reg_q;
        in_data   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cmd_ready = 1'b0;
        remaining = 8'd0;
        unique case (state)
            IDLE: cmd_ready = 1'b1;
            RUN: begin
                busy      = 1'b1;
                remaining = cnt;
                ctr       = op_q;
                if (op_q == OP_LOAD) begin
                    load_val = data_q;
                end
                if (op_q == OP_SHIFT) begin
                    in_data = fb_q ? (^(reg_q & TAPS)) : data_q[idx];
                end
            end
            DONE:    done = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Self-checking bench for shift_reg_sequencer, with a behavioural model of the
// external multi-mode shift register sampling ctr/load_val/in_data on negedge.
module tb_shift_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_len;
    logic [7:0] cmd_data;
    logic       cmd_fb;
    logic       abort;
    logic [7:0] reg_q;
    logic [2:0] ctr;
    logic [7:0] load_val;
    logic       in_data;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    logic       preset_en;
    logic [7:0] preset_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] preset;
        logic [2:0] op;
        logic [7:0] len;
        logic [7:0] data;
        logic       fb;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[8];

    shift_reg_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .cmd_fb    (cmd_fb),
        .abort     (abort),
        .reg_q     (reg_q),
        .ctr       (ctr),
        .load_val  (load_val),
        .in_data   (in_data),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    // Ops 1 load, 5 shift right with in_data into MSB, 6 rotate right, 7 rotate left.
    always @(negedge clk) begin
        if (preset_en) begin
            reg_q <= preset_val;
        end else begin
            case (ctr)
                3'd0: reg_q <= 8'h00;
                3'd1: reg_q <= load_val;
                3'd2: reg_q <= {reg_q[6:0], 1'b0};
                3'd3: reg_q <= {1'b0, reg_q[7:1]};
                3'd4: reg_q <= {reg_q[6:0], in_data};
                3'd5: reg_q <= {in_data, reg_q[7:1]};
                3'd6: reg_q <= {reg_q[0], reg_q[7:1]};
                default: reg_q <= {reg_q[6:0], reg_q[7]};
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic presetReg(input logic [7:0] val);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = val;
        @(negedge clk);
        #1;
        preset_en = 1'b0;
    endtask

    // Offers a command for one edge; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] len,
                                 input logic [7:0] data, input logic fb);
        @(negedge clk);
        #1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_fb    = fb;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        cmd_op    = 3'd0;
    endtask

    task automatic waitRemaining(input logic [7:0] val, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy && remaining == val) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] exp3[3];
        logic       seen[256];
        logic       ok;
        logic       bad_zero;
        logic       bad_rep;
        int         cyc;
        int         applied;

        vecs[0] = '{8'hA5, 3'd1, 8'd1,  8'h3C, 1'b0, 8'h3C};
        vecs[1] = '{8'h81, 3'd7, 8'd3,  8'h00, 1'b0, 8'h0C};
        vecs[2] = '{8'h00, 3'd5, 8'd8,  8'hB2, 1'b0, 8'hB2};
        vecs[3] = '{8'h5A, 3'd5, 8'd0,  8'hFF, 1'b0, 8'h5A};
        vecs[4] = '{8'h01, 3'd6, 8'd4,  8'h00, 1'b0, 8'h10};
        vecs[5] = '{8'h00, 3'd5, 8'd10, 8'h03, 1'b0, 8'hC0};
        vecs[6] = '{8'hF0, 3'd1, 8'd3,  8'h77, 1'b0, 8'h77};
        vecs[7] = '{8'h01, 3'd5, 8'd1,  8'h00, 1'b1, 8'h80};

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_len    = 8'd0;
        cmd_data   = 8'd0;
        cmd_fb     = 1'b0;
        abort      = 1'b0;
        preset_en  = 1'b0;
        preset_val = 8'h00;

        presetReg(8'hA5);
        checkOutput("reset_status", {11'd0, cmd_ready, busy, done, ctr[1:0]}, {11'd0, 1'b1, 1'b0, 1'b0, 2'd1});
        checkOutput("reset_remaining", {8'd0, remaining}, 16'd0);
        rst = 1'b0;

        // Idle hold: load-self every cycle keeps the register unchanged.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("idle_hold_%0d", i), {5'd0, ctr, load_val}, {5'd0, 3'd1, 8'hA5});
        end
        checkOutput("idle_reg", {8'd0, reg_q}, {8'd0, 8'hA5});

        for (int v = 0; v < 8; v++) begin
            presetReg(vecs[v].preset);
            applyStimulus(vecs[v].op, vecs[v].len, vecs[v].data, vecs[v].fb);
            cyc = 1;
            while (!done && cyc < 300) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            checkOutput($sformatf("vec%0d_done_cycle", v), cyc[15:0], {8'd0, vecs[v].len} + 16'd1);
            checkOutput($sformatf("vec%0d_reg", v), {8'd0, reg_q}, {8'd0, vecs[v].exp_q});
            checkOutput($sformatf("vec%0d_done_ready", v), {14'd0, cmd_ready, ctr == 3'd1}, {14'd0, 1'b0, 1'b1});
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_back_idle", v), {14'd0, cmd_ready, done}, {14'd0, 1'b1, 1'b0});
        end

        // Rotate-left sequence, checked every cycle.
        exp3[0] = 8'h03;
        exp3[1] = 8'h06;
        exp3[2] = 8'h0C;
        presetReg(8'h81);
        applyStimulus(3'd7, 8'd3, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("rol_remaining_%0d", k), {8'd0, remaining}, 16'd3 - 16'(k));
            checkOutput($sformatf("rol_ctr_%0d", k), {4'd0, busy, ctr, load_val}, {4'd0, 1'b1, 3'd7, reg_q});
            @(negedge clk);
            #1;
            checkOutput($sformatf("rol_reg_%0d", k), {8'd0, reg_q}, {8'd0, exp3[k]});
            @(posedge clk);
            #1;
        end
        checkOutput("rol_done", {15'd0, done}, 16'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rol_hold", {8'd0, reg_q}, {8'd0, 8'h0C});

        // Full LFSR period from 8'h01.
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[1]  = 1'b1;
        bad_zero = 1'b0;
        bad_rep  = 1'b0;
        applied  = 0;
        cyc      = 0;
        presetReg(8'h01);
        applyStimulus(3'd5, 8'd255, 8'h00, 1'b1);
        while (!done && cyc < 400) begin
            @(negedge clk);
            #1;
            if (busy) begin
                applied++;
                if (reg_q == 8'h00) bad_zero = 1'b1;
                if (applied < 255) begin
                    if (seen[reg_q]) bad_rep = 1'b1;
                    seen[reg_q] = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("lfsr_done", {15'd0, done}, 16'd1);
        checkOutput("lfsr_applied", applied[15:0], 16'd255);
        checkOutput("lfsr_final", {8'd0, reg_q}, {8'd0, 8'h01});
        checkOutput("lfsr_zero_or_repeat", {14'd0, bad_zero, bad_rep}, 16'd0);
        @(posedge clk);
        #1;

        // Abort sampled at the edge that would have shown remaining=6.
        presetReg(8'h01);
        applyStimulus(3'd6, 8'd10, 8'h00, 1'b0);
        waitRemaining(8'd7, ok);
        checkOutput("abort_reach_7", {15'd0, ok}, 16'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_state", {13'd0, cmd_ready, busy, done}, {13'd0, 1'b1, 1'b0, 1'b0});
        ok = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) ok = 1'b1;
        end
        checkOutput("abort_no_done", {15'd0, ok}, 16'd0);
        checkOutput("abort_reg", {8'd0, reg_q}, {8'd0, 8'h10});

        // Reset while remaining=5, before that cycle's op is applied.
        presetReg(8'h01);
        applyStimulus(3'd6, 8'd10, 8'h00, 1'b0);
        waitRemaining(8'd5, ok);
        checkOutput("rst_reach_5", {15'd0, ok}, 16'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_hold", {12'd0, busy, ctr}, {12'd0, 1'b0, 3'd1});
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_reg", {8'd0, reg_q}, {8'd0, 8'h08});
        checkOutput("rst_idle", {14'd0, cmd_ready, done}, {14'd0, 1'b1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
